// File: rtl/dmem_arbiter_if.sv
// Requester channel between one memory client and the data-memory arbiter.
// The requester drives the master modport; the arbiter uses the slave modport.
interface dmem_arbiter_if #(
    parameter int unsigned ADDR_W = 29,
    parameter int unsigned DATA_W = 64
) ();
    logic                  req;
    logic                  we;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wmask;
    logic                  gnt;
    logic                  rvalid;
    logic [DATA_W-1:0]     rdata;

    modport master (
        output req, we, addr, wdata, wmask,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, wmask,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of a single data memory. Writes complete in the
// grant cycle (one per cycle); a read blocks further grants until its data returns.
module dmem_arbiter #(
    parameter int unsigned ADDR_W     = 29,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned ARB_MODE   = 0
) (
    input  logic                clk,
    input  logic                rst,
    dmem_arbiter_if.slave       m0,
    dmem_arbiter_if.slave       m1,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wr_en,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic [DATA_W-1:0]   mem_rdata
);
    localparam int unsigned CntW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e          state_q, state_d;
    logic            owner_q, owner_d;   // requester whose read is outstanding
    logic            prio_q, prio_d;     // requester favoured on a tie (0 = m0)
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      rvalid_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;

    logic winner;
    logic gnt0, gnt1;
    logic capture;
    logic sel_we;

    assign m0.gnt    = gnt0;
    assign m1.gnt    = gnt1;
    assign m0.rvalid = rvalid_q[0];
    assign m1.rvalid = rvalid_q[1];
    assign m0.rdata  = rdata0_q;
    assign m1.rdata  = rdata1_q;

    // Arbitration, memory bus drive and next-state selection.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        prio_d    = prio_q;
        cnt_d     = cnt_q;
        capture   = 1'b0;
        winner    = 1'b0;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        sel_we    = 1'b0;
        mem_addr  = '0;
        mem_wr_en = 1'b0;
        mem_wdata = '0;
        mem_wmask = '0;
        // Held in reset: nothing is granted and the bus stays quiet.
        if (!rst) begin
            unique case (state_q)
                StIdle: begin
                    if (m0.req || m1.req) begin
                        if (m0.req && m1.req) begin
                            winner = (ARB_MODE == 1) ? 1'b0 : prio_q;
                        end else begin
                            winner = m1.req;
                        end
                        gnt0      = ~winner;
                        gnt1      = winner;
                        prio_d    = ~winner;
                        sel_we    = winner ? m1.we : m0.we;
                        mem_addr  = winner ? m1.addr : m0.addr;
                        mem_wdata = winner ? m1.wdata : m0.wdata;
                        mem_wr_en = sel_we;
                        if (sel_we) begin
                            mem_wmask = winner ? m1.wmask : m0.wmask;
                        end else begin
                            state_d = StWait;
                            owner_d = winner;
                            cnt_d   = '0;
                        end
                    end
                end
                StWait: begin
                    // Last wait cycle: memory data is valid now.
                    if (cnt_q == CntW'(RD_LATENCY - 1)) begin
                        capture = 1'b1;
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State, pointer and read-return registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            owner_q  <= 1'b0;
            prio_q   <= 1'b0;
            cnt_q    <= '0;
            rvalid_q <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            prio_q   <= prio_d;
            cnt_q    <= cnt_d;
            rvalid_q <= '0;
            if (capture) begin
                rvalid_q[owner_q] <= 1'b1;
                if (owner_q) begin
                    rdata1_q <= mem_rdata;
                end else begin
                    rdata0_q <= mem_rdata;
                end
            end
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_dmem_arbiter;
    localparam int unsigned AW = 29;
    localparam int unsigned DW = 64;
    localparam int unsigned RDL = 1;

    logic clk;
    logic rst;
    int n_checks = 0;
    int n_errors = 0;

    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_if ();
    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_if ();
    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) fp0_if ();
    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) fp1_if ();

    logic [AW-1:0] mem_addr, fp_mem_addr;
    logic          mem_wr_en, fp_mem_wr_en;
    logic [DW-1:0] mem_wdata, fp_mem_wdata, mem_rdata;
    logic [7:0]    mem_wmask, fp_mem_wmask;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(RDL), .ARB_MODE(0)) dut (
        .clk(clk), .rst(rst), .m0(m0_if.slave), .m1(m1_if.slave),
        .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
    );

    // Fixed-priority instance sees the same requests.
    assign fp0_if.req = m0_if.req;   assign fp1_if.req = m1_if.req;
    assign fp0_if.we = m0_if.we;     assign fp1_if.we = m1_if.we;
    assign fp0_if.addr = m0_if.addr; assign fp1_if.addr = m1_if.addr;
    assign fp0_if.wdata = m0_if.wdata; assign fp1_if.wdata = m1_if.wdata;
    assign fp0_if.wmask = m0_if.wmask; assign fp1_if.wmask = m1_if.wmask;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(RDL), .ARB_MODE(1)) dut_fp (
        .clk(clk), .rst(rst), .m0(fp0_if.slave), .m1(fp1_if.slave),
        .mem_addr(fp_mem_addr), .mem_wr_en(fp_mem_wr_en), .mem_wdata(fp_mem_wdata),
        .mem_wmask(fp_mem_wmask), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: masked write, registered read of one cycle.
    logic [DW-1:0] bmem [64];
    initial for (int i = 0; i < 64; i++) bmem[i] = '0;
    always @(posedge clk) begin
        if (mem_wr_en)
            for (int b = 0; b < 8; b++)
                if (mem_wmask[b]) bmem[mem_addr[5:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
        mem_rdata <= bmem[mem_addr[5:0]];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model state (values the DUT should show in the current cycle).
    bit            busy = 0;
    bit            pend_owner = 0;
    logic [63:0]   pend_data = '0;
    int            wait_left = 0;
    bit [1:0]      rv_exp = '0;
    logic [63:0]   rd_exp [2] = '{64'h0, 64'h0};
    bit            last = 1;             // last granted requester; m0 goes first
    logic [63:0]   mmem [64];
    initial for (int i = 0; i < 64; i++) mmem[i] = '0;

    // Per-cycle comparison against the model, then advance the model across the edge.
    always @(negedge clk) begin : cmp
        logic r0, r1, w, gt, we;
        logic [AW-1:0] a;
        logic [63:0] d;
        logic [7:0] m;
        bit [1:0] nrv;
        r0 = m0_if.req;
        r1 = m1_if.req;
        chk("rvalid0", m0_if.rvalid, rv_exp[0]);
        chk("rvalid1", m1_if.rvalid, rv_exp[1]);
        chk("rdata0", m0_if.rdata, rd_exp[0]);
        chk("rdata1", m1_if.rdata, rd_exp[1]);
        if (rst) begin
            chk("rst_gnt0", m0_if.gnt, 0);
            chk("rst_gnt1", m1_if.gnt, 0);
            chk("rst_wr_en", mem_wr_en, 0);
            chk("rst_wmask", mem_wmask, 0);
            busy = 0; rv_exp = '0; rd_exp[0] = '0; rd_exp[1] = '0; last = 1;
        end else begin
            gt = !busy && (r0 || r1);
            w  = (r0 && r1) ? ~last : r1;
            chk("gnt0", m0_if.gnt, gt && !w);
            chk("gnt1", m1_if.gnt, gt && w);
            we = w ? m1_if.we : m0_if.we;
            a  = w ? m1_if.addr : m0_if.addr;
            d  = w ? m1_if.wdata : m0_if.wdata;
            m  = w ? m1_if.wmask : m0_if.wmask;
            if (gt) begin
                chk("mem_wr_en", mem_wr_en, we);
                chk("mem_addr", mem_addr, a);
                chk("mem_wdata", mem_wdata, d);
                chk("mem_wmask", mem_wmask, we ? m : 8'h00);
                last = w;
            end else begin
                chk("idle_wr_en", mem_wr_en, 0);
                chk("idle_wmask", mem_wmask, 0);
                if (!busy) chk("idle_addr", mem_addr, 0);
            end
            nrv = '0;
            if (busy) begin
                wait_left--;
                if (wait_left == 0) begin
                    nrv[pend_owner] = 1'b1;
                    rd_exp[pend_owner] = pend_data;
                    busy = 0;
                end
            end
            if (gt) begin
                if (we) begin
                    for (int b = 0; b < 8; b++)
                        if (m[b]) mmem[a[5:0]][8*b +: 8] = d[8*b +: 8];
                end else begin
                    busy = 1; pend_owner = w; pend_data = mmem[a[5:0]]; wait_left = RDL;
                end
            end
            rv_exp = nrv;
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic mid();
        @(negedge clk); #1;
    endtask

    task automatic gen(output logic req, output logic we, output logic [AW-1:0] addr,
                       output logic [63:0] wdata, output logic [7:0] wmask);
        req   = ($urandom_range(0, 2) != 0);
        we    = $urandom_range(0, 1);
        addr  = AW'($urandom_range(0, 15));
        wdata = {$urandom, $urandom};
        case ($urandom_range(0, 3))
            0:       wmask = 8'h00;
            1:       wmask = 8'hFF;
            default: wmask = 8'($urandom);
        endcase
    endtask

    initial begin
        logic g0, g1;
        rst = 1'b1;
        m0_if.req = 1; m0_if.we = 1; m0_if.addr = 10; m0_if.wdata = 64'h1111; m0_if.wmask = 8'hFF;
        m1_if.req = 1; m1_if.we = 1; m1_if.addr = 11; m1_if.wdata = 64'h2222; m1_if.wmask = 8'hFF;
        // Reset held two cycles with both requesting.
        for (int k = 0; k < 2; k++) begin
            mid();
            chk("t1_gnt0", m0_if.gnt, 0);
            chk("t1_gnt1", m1_if.gnt, 0);
            chk("t1_wr_en", mem_wr_en, 0);
            chk("t1_rdata0", m0_if.rdata, 0);
        end
        step(); rst = 1'b0;
        // Continuous writes from both: alternate in RR, m0 always in fixed priority.
        for (int k = 0; k < 6; k++) begin
            mid();
            chk("t3_rr_gnt0", m0_if.gnt, (k % 2) == 0);
            chk("t3_rr_gnt1", m1_if.gnt, (k % 2) == 1);
            chk("t3_fp_gnt0", fp0_if.gnt, 1);
            chk("t3_fp_gnt1", fp1_if.gnt, 0);
            chk("t3_fp_addr", fp_mem_addr, 10);
            chk("t3_fp_wr_en", fp_mem_wr_en, 1);
            chk("t3_fp_wdata", fp_mem_wdata, 64'h1111);
            chk("t3_fp_wmask", fp_mem_wmask, 8'hFF);
            chk("t3_fp_rvalid", fp0_if.rvalid, 0);
        end
        step();
        m1_if.req = 0;
        m0_if.we = 1; m0_if.addr = 4; m0_if.wdata = 64'hDEADBEEF_CAFEF00D; m0_if.wmask = 8'hFF;
        mid(); chk("t2_wgnt", m0_if.gnt, 1); chk("t2_wr_en", mem_wr_en, 1);
        step(); m0_if.we = 0;
        mid(); chk("t2_rgnt", m0_if.gnt, 1); chk("t2_rd_wr_en", mem_wr_en, 0);
        step(); m0_if.req = 0;
        mid(); chk("t2_rv_t1", m0_if.rvalid, 0);
        step();
        mid(); chk("t2_rv_t2", m0_if.rvalid, 1);
        chk("t2_rdata", m0_if.rdata, 64'hDEADBEEF_CAFEF00D);
        chk("t2_rv1", m1_if.rvalid, 0);
        step();
        mid(); chk("t2_rv_t3", m0_if.rvalid, 0);
        // m1 read while m0 waits with a write.
        step();
        m1_if.req = 1; m1_if.we = 0; m1_if.addr = 5;
        m0_if.req = 1; m0_if.we = 1; m0_if.addr = 7; m0_if.wdata = 64'h77; m0_if.wmask = 8'hFF;
        mid(); chk("t4_m1gnt", m1_if.gnt, 1); chk("t4_m0gnt_t", m0_if.gnt, 0);
        step(); m1_if.req = 0;
        mid(); chk("t4_m0gnt_t1", m0_if.gnt, 0);
        step();
        mid(); chk("t4_m0gnt_t2", m0_if.gnt, 1); chk("t4_m1rv", m1_if.rvalid, 1);
        chk("t4_m1rdata", m1_if.rdata, 0);
        step(); m0_if.req = 0;
        // Partial-byte write.
        m0_if.req = 1; m0_if.we = 1; m0_if.addr = 6; m0_if.wdata = 64'h0; m0_if.wmask = 8'hFF;
        mid(); chk("t5_gnt_a", m0_if.gnt, 1);
        step(); m0_if.wdata = 64'hFFFF_FFFF_FFFF_FFFF; m0_if.wmask = 8'h03;
        mid(); chk("t5_gnt_b", m0_if.gnt, 1); chk("t5_wmask", mem_wmask, 8'h03);
        step(); m0_if.we = 0;
        mid(); chk("t5_gnt_r", m0_if.gnt, 1);
        step(); m0_if.req = 0;
        mid();
        step();
        mid(); chk("t5_rv", m0_if.rvalid, 1); chk("t5_rdata", m0_if.rdata, 64'h0000_0000_0000_FFFF);
        // Reset during the wait of an m0 read.
        step(); m0_if.req = 1; m0_if.we = 0; m0_if.addr = 4;
        mid(); chk("t6_rgnt", m0_if.gnt, 1);
        step(); m0_if.req = 0; rst = 1;
        m1_if.req = 1; m1_if.we = 1; m1_if.addr = 8; m1_if.wdata = 64'h88; m1_if.wmask = 8'hFF;
        mid(); chk("t6_rst_gnt1", m1_if.gnt, 0);
        step(); rst = 0;
        mid(); chk("t6_m1gnt", m1_if.gnt, 1); chk("t6_rv0", m0_if.rvalid, 0);
        chk("t6_rdata0", m0_if.rdata, 0);
        step(); m1_if.req = 0;
        mid(); chk("t6_rv0_late", m0_if.rvalid, 0);
        // Random traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            g0 = m0_if.gnt;
            g1 = m1_if.gnt;
            step();
            rst = ($urandom_range(0, 99) == 0);
            if (!m0_if.req || g0)
                gen(m0_if.req, m0_if.we, m0_if.addr, m0_if.wdata, m0_if.wmask);
            if (!m1_if.req || g1)
                gen(m1_if.req, m1_if.we, m1_if.addr, m1_if.wdata, m1_if.wmask);
        end
        step();
        m0_if.req = 0; m1_if.req = 0; rst = 0;
        repeat (4) step();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
